// File: rtl/result_writer.sv
// ============================================================================
//  Module   : result_writer
//  Collects per-pixel results from a pool of engines over a shared bus,
//  buffers them, and streams {address, iteration} writes to the frame RAM.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_writer #(
  parameter int NUM_PROC   = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480
) (
  input  logic                          clk_iCLK,
  input  logic                          iRST_N,
  input  logic [NUM_PROC-1:0]           engine_req,
  output logic [NUM_PROC-1:0]           req_ack,
  input  logic [26:0]                   engine_word,
  input  logic                          wr_ready,
  output logic                          write_iWR_en,
  output logic [18:0]                   address_iADDR,
  output logic [7:0]                    writedata_iDATA,
  output logic                          frame_done,
  output logic                          coord_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int RR_W  = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
  localparam int ENT_W = 28;
  localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t          state;
  logic [RR_W-1:0] rr_ptr;
  logic [RR_W-1:0] winner;
  logic [RR_W-1:0] cand;
  logic            found;

  // Round-robin search: first requester strictly after the last grant.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    cand   = '0;
    for (int k = 1; k <= NUM_PROC; k++) begin
      cand = RR_W'((int'(rr_ptr) + k) % NUM_PROC);
      if (!found && engine_req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  logic [9:0]  cap_x;
  logic [8:0]  cap_y;
  logic [7:0]  cap_iter;
  logic [18:0] cap_addr;
  logic        cap_in_range;
  logic        cap_last;
  logic        push;
  logic        pop;
  logic        load;

  assign cap_x        = engine_word[26:17];
  assign cap_y        = engine_word[16:8];
  assign cap_iter     = engine_word[7:0];
  assign cap_in_range = (int'(cap_x) < H_RES) && (int'(cap_y) < V_RES);
  assign cap_last     = (int'(cap_x) == H_RES - 1) && (int'(cap_y) == V_RES - 1);
  assign push         = (state == CAPTURE) && cap_in_range;

  generate
    if (H_RES == 640) begin : g_addr_shift
      assign cap_addr = 19'(cap_x) + (19'(cap_y) << 9) + (19'(cap_y) << 7);
    end else begin : g_addr_mul
      assign cap_addr = 19'(cap_x) + 19'(cap_y) * 19'(H_RES);
    end
  endgenerate

  always_ff @(posedge clk_iCLK) begin
    if (!iRST_N) begin
      state     <= IDLE;
      rr_ptr    <= RR_W'(NUM_PROC - 1);
      req_ack   <= '0;
      coord_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ack <= '0;
          if (found && (fifo_level < LVL_FULL)) begin
            state   <= ACK;
            rr_ptr  <= winner;
            req_ack <= NUM_PROC'(1) << winner;
          end
        end
        ACK: begin
          req_ack <= '0;
          state   <= CAPTURE;
        end
        CAPTURE: begin
          state <= IDLE;
          if (!cap_in_range) begin
            coord_err <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          req_ack <= '0;
        end
      endcase
    end
  end

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             out_last;

  // Output register refills whenever it is empty or being drained this cycle.
  assign load       = !write_iWR_en || wr_ready;
  assign pop        = load && (fifo_level != '0);
  assign frame_done = write_iWR_en && wr_ready && out_last;

  always_ff @(posedge clk_iCLK) begin
    if (iRST_N && push) begin
      mem[wr_ptr] <= {cap_last, cap_addr, cap_iter};
    end
  end

  always_ff @(posedge clk_iCLK) begin
    if (!iRST_N) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_level      <= '0;
      write_iWR_en    <= 1'b0;
      address_iADDR   <= '0;
      writedata_iDATA <= '0;
      out_last        <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (load) begin
        write_iWR_en <= (fifo_level != '0);
        if (pop) begin
          {out_last, address_iADDR, writedata_iDATA} <= mem[rd_ptr];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_result_writer.sv
// ============================================================================
//  Module   : tb_result_writer
//  Self-checking bench for result_writer: engine environment, queue-based
//  reference model, per-cycle compare process and directed scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_writer;

  localparam int NP = 12;
  localparam int FD = 8;
  localparam int HR = 640;
  localparam int VR = 480;

  logic          clk_iCLK = 1'b0;
  logic          iRST_N = 1'b0;
  logic [NP-1:0] engine_req = '0;
  logic [NP-1:0] req_ack;
  logic [26:0]   engine_word = '0;
  logic          wr_ready = 1'b1;
  logic          write_iWR_en;
  logic [18:0]   address_iADDR;
  logic [7:0]    writedata_iDATA;
  logic          frame_done;
  logic          coord_err;
  logic [3:0]    fifo_level;

  result_writer #(
    .NUM_PROC(NP), .FIFO_DEPTH(FD), .H_RES(HR), .V_RES(VR)
  ) dut (
    .clk_iCLK(clk_iCLK), .iRST_N(iRST_N), .engine_req(engine_req),
    .req_ack(req_ack), .engine_word(engine_word), .wr_ready(wr_ready),
    .write_iWR_en(write_iWR_en), .address_iADDR(address_iADDR),
    .writedata_iDATA(writedata_iDATA), .frame_done(frame_done),
    .coord_err(coord_err), .fifo_level(fifo_level)
  );

  always #5 clk_iCLK = ~clk_iCLK;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int mode = 0;  // 0 manual, 1 continuous requests, 2 random traffic
  logic [26:0] word_of [NP];

  always @(posedge clk_iCLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [26:0] mkword(input int x, input int y, input int it);
    return {x[9:0], y[8:0], it[7:0]};
  endfunction

  function automatic logic [26:0] word_ok();
    return mkword($urandom_range(0, HR-1), $urandom_range(0, VR-1), $urandom_range(0, 255));
  endfunction

  function automatic logic [26:0] word_any();
    int r = $urandom_range(0, 99);
    if (r < 5)  return mkword(HR + $urandom_range(0, 383), $urandom_range(0, VR-1), $urandom_range(0, 255));
    if (r < 8)  return mkword($urandom_range(0, HR-1), VR + $urandom_range(0, 31), $urandom_range(0, 255));
    if (r < 11) return mkword(HR-1, VR-1, $urandom_range(0, 255));
    return word_ok();
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        last;
    logic [18:0] addr;
    logic [7:0]  data;
  } item_t;

  item_t         mq[$];
  item_t         m_out;
  bit            m_out_v = 0;
  int            m_busy = 0;   // cycles left in the current grant after the ack cycle
  int            m_ptr = NP-1;
  int            m_lvl;
  int            m_win;
  int            mx, my;
  bit            m_found;
  bit            m_err = 0;
  logic [NP-1:0] m_ack = '0;
  logic [26:0]   m_word;

  always @(posedge clk_iCLK) begin
    if (!iRST_N) begin
      mq.delete();
      m_out_v = 0;
      m_busy  = 0;
      m_ptr   = NP-1;
      m_err   = 0;
      m_ack   = '0;
    end else begin
      m_lvl = mq.size();
      if (!m_out_v || wr_ready) begin
        if (mq.size() > 0) begin
          m_out   = mq.pop_front();
          m_out_v = 1;
        end else begin
          m_out_v = 0;
        end
      end
      m_ack = '0;
      if (m_busy == 0) begin
        if (engine_req != '0 && m_lvl < FD) begin
          m_found = 0;
          m_win   = m_ptr;
          for (int k = 1; k <= NP; k++) begin
            if (!m_found && engine_req[(m_ptr + k) % NP]) begin
              m_found = 1;
              m_win   = (m_ptr + k) % NP;
            end
          end
          m_ptr        = m_win;
          m_ack[m_win] = 1'b1;
          m_word       = word_of[m_win];
          m_busy       = 2;
        end
      end else begin
        if (m_busy == 1) begin
          mx = int'(m_word[26:17]);
          my = int'(m_word[16:8]);
          if (mx < HR && my < VR)
            mq.push_back('{last: (mx == HR-1 && my == VR-1), addr: 19'(mx + my*HR), data: m_word[7:0]});
          else
            m_err = 1;
        end
        m_busy--;
      end
    end
  end

  always @(posedge clk_iCLK) begin
    #1;
    chk("req_ack", req_ack, m_ack);
    chk("write_en", write_iWR_en, m_out_v);
    if (m_out_v) begin
      chk("address", address_iADDR, m_out.addr);
      chk("data", writedata_iDATA, m_out.data);
    end
    chk("fifo_level", fifo_level, mq.size());
    chk("coord_err", coord_err, m_err);
    chk("frame_done", frame_done, m_out_v && wr_ready && m_out.last);
  end

  // ---------------- engine environment / driver ----------------
  task automatic tick();
    @(negedge clk_iCLK);
    for (int i = 0; i < NP; i++) begin
      if (req_ack[i]) begin
        engine_word   = word_of[i];
        engine_req[i] = 1'b0;
        if (mode == 1) begin
          word_of[i]    = word_ok();
          engine_req[i] = 1'b1;
        end
      end else if (mode == 2 && !engine_req[i] && $urandom_range(0, 3) == 0) begin
        word_of[i]    = word_any();
        engine_req[i] = 1'b1;
      end
    end
    if (mode == 2) wr_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_ack(output logic [NP-1:0] a);
    bit done = 0;
    a = '0;
    for (int n = 0; n < 20 && !done; n++) begin
      tick();
      if (req_ack != '0) begin
        a    = req_ack;
        done = 1;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, req_ack, 0);
    chk({tag, "_wr_en"}, write_iWR_en, 0);
    chk({tag, "_addr"}, address_iADDR, 0);
    chk({tag, "_data"}, writedata_iDATA, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_coord_err"}, coord_err, 0);
    chk({tag, "_level"}, fifo_level, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [NP-1:0] a;
    int idx_q[$];
    int cyc_q[$];
    int n_ack;
    int n_wr;
    bit hit;

    for (int i = 0; i < NP; i++) word_of[i] = '0;
    iRST_N = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    iRST_N = 1'b1;
    tick();

    // Single request from engine 2
    word_of[2] = mkword(5, 2, 'h3C);
    engine_req = 12'h004;
    wait_ack(a);
    chk("single_ack", a, 12'h004);
    tick();
    tick();
    chk("single_wr_T2", write_iWR_en, 0);
    tick();
    chk("single_wr_T3", write_iWR_en, 1);
    chk("single_addr", address_iADDR, 1285);
    chk("single_data", writedata_iDATA, 'h3C);
    repeat (3) tick();

    // Last pixel of the frame
    word_of[0] = mkword(639, 479, 7);
    engine_req[0] = 1'b1;
    wait_ack(a);
    chk("last_ack", a, 12'h001);
    repeat (3) tick();
    chk("last_addr", address_iADDR, 307199);
    chk("last_frame_done", frame_done, 1);
    tick();
    chk("last_frame_done_off", frame_done, 0);

    // Out-of-range coordinate is dropped
    word_of[5] = mkword(640, 0, 9);
    engine_req[5] = 1'b1;
    wait_ack(a);
    chk("oor_ack", a, 12'h020);
    repeat (4) tick();
    chk("oor_coord_err", coord_err, 1);
    chk("oor_no_write", write_iWR_en, 0);
    chk("oor_level", fifo_level, 0);

    // Round robin with all engines requesting
    iRST_N = 1'b0;
    tick();
    tick();
    chk("rst_clears_err", coord_err, 0);
    iRST_N = 1'b1;
    mode = 1;
    for (int i = 0; i < NP; i++) word_of[i] = word_ok();
    engine_req = '1;
    for (int n = 0; n < 100 && idx_q.size() < 13; n++) begin
      tick();
      if (req_ack != '0) begin
        for (int i = 0; i < NP; i++) if (req_ack[i]) idx_q.push_back(i);
        cyc_q.push_back(cyc);
      end
    end
    chk("rr_count", idx_q.size(), 13);
    for (int k = 0; k < idx_q.size(); k++) begin
      chk("rr_order", idx_q[k], k % NP);
      if (k > 0) chk("rr_gap", cyc_q[k] - cyc_q[k-1], 3);
    end

    // Back-pressure fills the buffer without losing results
    wr_ready = 1'b0;
    n_ack = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (n >= 36 && req_ack != '0) n_ack++;
    end
    chk("full_level", fifo_level, 8);
    chk("full_no_ack", n_ack, 0);
    mode = 0;
    engine_req = '0;
    wr_ready = 1'b1;
    n_wr = 0;
    for (int n = 0; n < 30; n++) begin
      if (write_iWR_en && wr_ready) n_wr++;
      tick();
    end
    chk("full_drain_writes", n_wr, 9);

    // Reset during CAPTURE with 3 entries buffered
    mode = 1;
    engine_req = '1;
    wr_ready = 1'b0;
    hit = 0;
    for (int n = 0; n < 60 && !hit; n++) begin
      tick();
      if (fifo_level == 3 && req_ack != '0) hit = 1;
    end
    chk("capture_rst_setup", hit, 1);
    tick();
    iRST_N = 1'b0;
    tick();
    chk_all_zero("capture_rst");
    iRST_N = 1'b1;
    wr_ready = 1'b1;
    engine_req = '1;
    wait_ack(a);
    chk("capture_rst_first_ack", a, 12'h001);

    // Randomized traffic
    mode = 2;
    engine_req = '0;
    repeat (3000) tick();

    mode = 0;
    engine_req = '0;
    wr_ready = 1'b1;
    repeat (30) tick();
    chk("drain_level", fifo_level, 0);
    chk("drain_wr_en", write_iWR_en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/result_writer.md
RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 SHALL have parameter NUM_PROC, default 12, number of calculating engines served.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, result buffer entries, power of 2, at least 2.
REQ-003 SHALL have parameter H_RES, default 640, pixels per line; V_RES, default 480, lines per frame.
REQ-004 SHALL have port clk_iCLK, input, 1, engine clock; all logic on its rising edge.
REQ-005 SHALL have port iRST_N, input, 1, synchronous active-low reset.
REQ-006 SHALL have port engine_req, input, NUM_PROC, per-engine result-ready request, held high until acked.
REQ-007 SHALL have port req_ack, output, NUM_PROC, one-hot one-cycle grant; the granted engine drives engine_word on the next cycle.
REQ-008 SHALL have port engine_word, input, 27, {x[26:17], y[16:8], iter[7:0]} from the shared engine bus.
REQ-009 SHALL have port wr_ready, input, 1, frame-buffer RAM accepts a write this cycle.
REQ-010 SHALL have port write_iWR_en, output, 1, write valid to the RAM.
REQ-011 SHALL have port address_iADDR, output, 19, pixel address x + y*H_RES.
REQ-012 SHALL have port writedata_iDATA, output, 8, iteration count.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse on the last-pixel write.
REQ-014 SHALL have port coord_err, output, 1, sticky flag: an out-of-range result was dropped.
REQ-015 SHALL have port fifo_level, output, log2(FIFO_DEPTH)+1, current buffer occupancy.

Function
REQ-016 Arbiter SHALL be an FSM with states IDLE, ACK and CAPTURE.
REQ-017 IDLE -> ACK SHALL occur when any engine_req bit is high and fifo_level < FIFO_DEPTH; otherwise the FSM SHALL stay in IDLE.
REQ-018 Winner SHALL be chosen round-robin: the first requesting index strictly after the last granted index, wrapping NUM_PROC-1 -> 0; the pointer starts at NUM_PROC-1 after reset, so engine 0 has first priority.
REQ-019 In ACK, req_ack SHALL be high for exactly the winner bit for exactly one cycle; ACK -> CAPTURE unconditionally.
REQ-020 In CAPTURE, engine_word SHALL be sampled and pushed into the FIFO at the closing edge; CAPTURE -> IDLE unconditionally.
REQ-021 A grant SHALL cost 3 cycles; the arbiter SHALL NOT issue a new ack before returning to IDLE.
REQ-022 A requester deasserting in ACK or CAPTURE SHALL NOT affect the in-flight capture.
REQ-023 Results with x >= H_RES or y >= V_RES SHALL NOT be pushed; coord_err SHALL set and hold until reset.
REQ-024 The output stage SHALL be one register holding {address_iADDR, writedata_iDATA} with valid shown as write_iWR_en.
REQ-025 The output register SHALL load from the FIFO head (pop) when it is empty, or when write_iWR_en && wr_ready in the same cycle.
REQ-026 The output register SHALL hold its value while write_iWR_en && !wr_ready.
REQ-027 Address SHALL be computed as x + (y<<9) + (y<<7) for the default H_RES (generic x + y*H_RES otherwise), 19-bit unsigned, no overflow for in-range coordinates.
REQ-028 Latency with an empty FIFO and wr_ready=1: req_ack high in cycle T; write_iWR_en high in cycle T+3.
REQ-029 A push and a pop in the same cycle SHALL leave fifo_level unchanged.
REQ-030 Push when full SHALL be impossible by construction (REQ-017); pop when empty SHALL NOT occur.
REQ-031 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 frame_done SHALL pulse for exactly one cycle, coincident with the transfer (write_iWR_en && wr_ready) of x=H_RES-1, y=V_RES-1.
REQ-033 Write ordering SHALL equal capture order.

Reset
REQ-034 While iRST_N=0 at a clock edge, the FSM SHALL go to IDLE and the RR pointer to NUM_PROC-1.
REQ-035 While iRST_N=0 at a clock edge, the FIFO SHALL empty, fifo_level=0 and the output register valid SHALL clear.
REQ-036 While iRST_N=0 at a clock edge, req_ack, write_iWR_en, address_iADDR, writedata_iDATA, frame_done and coord_err SHALL all be 0.
REQ-037 Reset asserted in ACK or CAPTURE SHALL discard that result; the engine's lost result is acceptable because engines reset concurrently.

Verification
REQ-038 Single request: engine_req=0x004, word {x=5, y=2, iter=0x3C}, wr_ready=1 -> req_ack=0x004 at T; write_iWR_en at T+3 with address 1285 and data 0x3C.
REQ-039 All 12 engines request continuously -> acks cycle 0,1,...,11,0 with one ack every 3 cycles and no engine granted twice before all others.
REQ-040 wr_ready=0 for 40 cycles under continuous requests -> fifo_level reaches 8, acks stop, no result lost; on wr_ready=1, 9 writes issue in capture order.
REQ-041 Word {x=639, y=479, iter=7} -> address 307199 and frame_done high for 1 cycle; word {x=640, y=0} -> no write and coord_err=1.
REQ-042 iRST_N=0 in the CAPTURE cycle with 3 entries buffered -> next cycle fifo_level=0 and all outputs 0; the first ack after release goes to engine 0 if it is requesting.
